// File: rtl/nn_tour_builder.sv
// nn_tour_builder
// Builds a greedy nearest-neighbour tour over N points once the upstream
// point generator reports its set complete. The tour starts at point 0.
// Each step scans all N candidates sequentially, one distance per clock, and
// then commits the nearest unvisited point. A closing edge back to point 0 is
// added to the total length at the end.
// Optional build macro: NN_TOUR_EUCLID_SQ_EN selects squared Euclidean
// distance instead of Manhattan distance. Tie rule and timing are the same
// with either metric.
module nn_tour_builder #(
  parameter int N       = 64,
  parameter int COORD_W = 8,
  localparam int IDX_W  = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              graph_done,
  input  logic [31:0]       xs [N-1:0],
  input  logic [31:0]       ys [N-1:0],
  output logic [IDX_W-1:0]  tour [N-1:0],
  output logic [31:0]       tour_len,
  output logic              busy,
  output logic              done
);

`ifdef NN_TOUR_EUCLID_SQ_EN
  localparam int DIST_W = 2 * COORD_W + 1;
`else
  localparam int DIST_W = COORD_W + 1;
`endif

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] INIT   = 3'd1;
  localparam logic [2:0] SCAN   = 3'd2;
  localparam logic [2:0] COMMIT = 3'd3;
  localparam logic [2:0] CLOSE  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N - 1);
  localparam logic [N-1:0]     START_MASK  = {{(N-1){1'b0}}, 1'b1};

  logic [2:0]        state;
  logic [IDX_W-1:0]  cur;
  logic [IDX_W-1:0]  j;
  logic [IDX_W-1:0]  step;
  logic [IDX_W-1:0]  best;
  logic [DIST_W-1:0] best_d;
  logic              best_valid;
  logic [N-1:0]      visited;

  logic [DIST_W-1:0] dist_scan;
  logic [DIST_W-1:0] dist_close;
  logic              unused_hi;

  // Distance between two points using only the low COORD_W coordinate bits.
  function automatic logic [DIST_W-1:0] dist_f(
    input logic [COORD_W-1:0] xa,
    input logic [COORD_W-1:0] ya,
    input logic [COORD_W-1:0] xb,
    input logic [COORD_W-1:0] yb
  );
    logic [COORD_W-1:0]   dx;
    logic [COORD_W-1:0]   dy;
`ifdef NN_TOUR_EUCLID_SQ_EN
    logic [2*COORD_W-1:0] dx_w;
    logic [2*COORD_W-1:0] dy_w;
`endif
    dx = (xa > xb) ? (xa - xb) : (xb - xa);
    dy = (ya > yb) ? (ya - yb) : (yb - ya);
`ifdef NN_TOUR_EUCLID_SQ_EN
    dx_w = (2*COORD_W)'(dx);
    dy_w = (2*COORD_W)'(dy);
    return DIST_W'(dx_w * dx_w) + DIST_W'(dy_w * dy_w);
`else
    return DIST_W'(dx) + DIST_W'(dy);
`endif
  endfunction

  // Candidate distance for the current scan slot and the closing edge to point 0.
  always_comb begin
    dist_scan  = dist_f(xs[cur][COORD_W-1:0], ys[cur][COORD_W-1:0],
                        xs[j][COORD_W-1:0],   ys[j][COORD_W-1:0]);
    dist_close = dist_f(xs[cur][COORD_W-1:0], ys[cur][COORD_W-1:0],
                        xs[0][COORD_W-1:0],   ys[0][COORD_W-1:0]);
  end

  // The upper coordinate bits are deliberately ignored; fold them into one
  // sink so that intent is explicit.
  always_comb begin
    unused_hi = 1'b0;
    for (int i = 0; i < N; i++) begin
      unused_hi = unused_hi ^ (^xs[i][31:COORD_W]) ^ (^ys[i][31:COORD_W]);
    end
  end

  // Control FSM and datapath: idle until graph_done, then scan/commit N-1 times,
  // add the closing edge, and hold the result until rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the tour array is an architectural output that must read all-zero
      // after reset, so it is reset element by element rather than left as
      // uninitialised storage.
      state      <= IDLE;
      for (int i = 0; i < N; i++) tour[i] <= '0;
      tour_len   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      visited    <= '0;
      cur        <= '0;
      j          <= '0;
      step       <= '0;
      best       <= '0;
      best_d     <= '0;
      best_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (graph_done) begin
            state <= INIT;
            busy  <= 1'b1;
          end
        end

        INIT: begin
          cur        <= '0;
          visited    <= START_MASK;
          for (int i = 0; i < N; i++) tour[i] <= '0;
          step       <= IDX_W'(1);
          tour_len   <= '0;
          j          <= '0;
          best_valid <= 1'b0;
          state      <= SCAN;
        end

        SCAN: begin
          // Strict less-than keeps the lowest index on ties, since j ascends.
          if (!visited[j] && (!best_valid || dist_scan < best_d)) begin
            best       <= j;
            best_d     <= dist_scan;
            best_valid <= 1'b1;
          end
          if (j == LAST_IDX) begin
            state <= COMMIT;
          end else begin
            j <= j + IDX_W'(1);
          end
        end

        COMMIT: begin
          tour[step]    <= best;
          tour_len      <= tour_len + 32'(best_d);
          visited[best] <= 1'b1;
          cur           <= best;
          if (step == LAST_IDX) begin
            state <= CLOSE;
          end else begin
            step       <= step + IDX_W'(1);
            j          <= '0;
            best_valid <= 1'b0;
            state      <= SCAN;
          end
        end

        CLOSE: begin
          tour_len <= tour_len + 32'(dist_close);
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= DONE;
        end

        DONE: begin
          // Result frozen; only rst rearms the block.
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_tour_builder.sv
// Directed testbench for nn_tour_builder: N=64 and N=4 instances with
// hand-computed tours, lengths and latencies.
module tb_nn_tour_builder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // N=64 instance
  logic        gd64;
  logic [31:0] xs64 [63:0];
  logic [31:0] ys64 [63:0];
  logic [5:0]  tour64 [63:0];
  logic [31:0] len64;
  logic        busy64;
  logic        done64;

  // N=4 instance
  logic        gd4;
  logic [31:0] xs4 [3:0];
  logic [31:0] ys4 [3:0];
  logic [1:0]  tour4 [3:0];
  logic [31:0] len4;
  logic        busy4;
  logic        done4;

  nn_tour_builder #(.N(64), .COORD_W(8)) dut64 (
    .clk(clk), .rst(rst), .graph_done(gd64), .xs(xs64), .ys(ys64),
    .tour(tour64), .tour_len(len64), .busy(busy64), .done(done64)
  );

  nn_tour_builder #(.N(4), .COORD_W(8)) dut4 (
    .clk(clk), .rst(rst), .graph_done(gd4), .xs(xs4), .ys(ys4),
    .tour(tour4), .tour_len(len4), .busy(busy4), .done(done4)
  );

`ifdef NN_TOUR_EUCLID_SQ_EN
  localparam logic [31:0] LINE_LEN = 32'd4032;   // 63*1 + 63^2
  localparam logic [31:0] SQ4_LEN  = 32'd26;     // 4+9+4+9
`else
  localparam logic [31:0] LINE_LEN = 32'd126;    // 63*1 + 63
  localparam logic [31:0] SQ4_LEN  = 32'd10;     // 2+3+2+3
`endif
  localparam int LAT64 = 63 * 65 + 2;  // 4097
  localparam int LAT4  = 3 * 5 + 2;    // 17
  localparam int BUDGET = 5000;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    gd64 = 1'b0;
    gd4  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Caller has set gd64=1 before the edge; this edge is E0. Counts edges
  // after E0 until done is seen.
  task automatic run64(input string tag, output int cycles);
    @(posedge clk);
    #1;
    check({tag, "_busy_rise"}, 32'(busy64), 32'd1);
    cycles = 0;
    while (cycles < BUDGET) begin
      @(posedge clk);
      cycles++;
      #1;
      if (done64) break;
    end
    check({tag, "_latency"}, cycles, LAT64);
  endtask

  task automatic check_identity64(input string tag);
    for (int k = 0; k < 64; k++)
      check($sformatf("%s_tour%0d", tag, k), 32'(tour64[k]), k);
  endtask

  int cyc;
  int nz;

  initial begin
    rst  = 1'b1;
    gd64 = 1'b0;
    gd4  = 1'b0;
    for (int i = 0; i < 64; i++) begin xs64[i] = '0; ys64[i] = '0; end
    for (int i = 0; i < 4; i++)  begin xs4[i]  = '0; ys4[i]  = '0; end

    // Reset state
    do_reset();
    #1;
    check("rst_busy", 32'(busy64), 32'd0);
    check("rst_done", 32'(done64), 32'd0);
    check("rst_len", len64, 32'd0);
    check("rst_done4", 32'(done4), 32'd0);

    // All points identical: lowest-index ties give identity tour, length 0
    for (int i = 0; i < 64; i++) begin xs64[i] = 32'd5; ys64[i] = 32'd5; end
    @(negedge clk); gd64 = 1'b1;
    run64("same", cyc);
    check("same_len", len64, 32'd0);
    check("same_busy_end", 32'(busy64), 32'd0);
    check_identity64("same");

    // Points on a line
    do_reset();
    for (int i = 0; i < 64; i++) begin xs64[i] = i; ys64[i] = 32'd0; end
    @(negedge clk); gd64 = 1'b1;
    run64("line", cyc);
    check("line_len", len64, LINE_LEN);
    check_identity64("line");

    // Hold graph_done high after done: result frozen
    repeat (1000) @(posedge clk);
    #1;
    check("hold_done", 32'(done64), 32'd1);
    check("hold_busy", 32'(busy64), 32'd0);
    check("hold_len", len64, LINE_LEN);
    check_identity64("hold");

    // Upper coordinate bits ignored
    do_reset();
    for (int i = 0; i < 64; i++) begin
      xs64[i] = 32'hFFFF_FF00 | i;
      ys64[i] = 32'h1234_5600;
    end
    @(negedge clk); gd64 = 1'b1;
    run64("upper", cyc);
    check("upper_len", len64, LINE_LEN);
    check_identity64("upper");

    // Reset in the middle of a build, then a fresh build
    do_reset();
    for (int i = 0; i < 64; i++) begin xs64[i] = i; ys64[i] = 32'd0; end
    @(negedge clk); gd64 = 1'b1;
    @(posedge clk);  // E0
    repeat (1000) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy64), 32'd1);
    check("mid_done", 32'(done64), 32'd0);
    check("mid_tour1", 32'(tour64[1]), 32'd1);
    check("mid_tour63", 32'(tour64[63]), 32'd0);
    check("mid_len_nz", 32'(len64 != 0), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_busy", 32'(busy64), 32'd0);
    check("mrst_done", 32'(done64), 32'd0);
    check("mrst_len", len64, 32'd0);
    nz = 0;
    for (int k = 0; k < 64; k++) if (tour64[k] != 0) nz++;
    check("mrst_tour_nonzero", nz, 32'd0);
    @(negedge clk); rst = 1'b0;  // graph_done still high
    run64("restart", cyc);
    check("restart_len", len64, LINE_LEN);
    check_identity64("restart");

    // N=4 instance: (0,0),(3,0),(0,2),(3,2)
    do_reset();
    xs4[0] = 0; ys4[0] = 0;
    xs4[1] = 3; ys4[1] = 0;
    xs4[2] = 0; ys4[2] = 2;
    xs4[3] = 3; ys4[3] = 2;
    @(negedge clk); gd4 = 1'b1;
    @(posedge clk);
    #1;
    check("n4_busy_rise", 32'(busy4), 32'd1);
    cyc = 0;
    while (cyc < BUDGET) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done4) break;
    end
    check("n4_latency", cyc, LAT4);
    check("n4_tour0", 32'(tour4[0]), 32'd0);
    check("n4_tour1", 32'(tour4[1]), 32'd2);
    check("n4_tour2", 32'(tour4[2]), 32'd3);
    check("n4_tour3", 32'(tour4[3]), 32'd1);
    check("n4_len", len4, SQ4_LEN);
    check("n4_busy_end", 32'(busy4), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
